outr_serial_tx: RTL and testbench

- Output side of the Basic Computer terminal interface, complementing the input register/FGI path.
- Holds the 8-bit output register OUTR and the FGO flag.
- On each OUT transfer, serializes OUTR onto a single line as a UART-style frame: start bit, 8 data bits LSB first, stop bit. Sets FGO when the frame is done, so SKO/interrupt logic sees the device as ready.
- Sits between the control unit (AC[7:0] -> OUTR load) and the external terminal pin.

---
 rtl/outr_serial_tx.sv | 102 ++++++++++
 tb/tb_outr_serial_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/outr_serial_tx.sv
// Output register OUTR with FGO flag; each accepted OUT load is sent on tx_serial
// as a start bit, 8 data bits LSB first and a stop bit.
module outr_serial_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] outr_indata,
  input  logic       outr_ld,
  output logic [7:0] outr_outdata,
  output logic       fgo_outdata,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       ovr_err
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    outr_q;
  logic          fgo_q;
  logic          tx_q;
  logic          ovr_q;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      outr_q  <= '0;
      fgo_q   <= 1'b1;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      // A load while FGO=0 (including the cycle FGO returns high) is an overrun.
      if (outr_ld && !fgo_q) ovr_q <= 1'b1;

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (outr_ld) begin
            outr_q  <= outr_indata;
            fgo_q   <= 1'b0;
            ovr_q   <= 1'b0;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= outr_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= outr_q[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            fgo_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outr_outdata = outr_q;
  assign fgo_outdata  = fgo_q;
  assign tx_serial    = tx_q;
  assign tx_busy      = ~fgo_q;
  assign ovr_err      = ovr_q;

endmodule

// File: tb/tb_outr_serial_tx.sv
// Bench for outr_serial_tx: two instances (4 and 2 clocks per bit) share stimulus and
// are compared every cycle against a frame-timeline model, plus literal frame checks.
module tb_outr_serial_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ld = 1'b0;

  logic [7:0] outr0, outr1;
  logic       fgo0, fgo1, tx0, tx1, busy0, busy1, ovr0, ovr1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  outr_serial_tx #(.CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .reset(reset), .outr_indata(din), .outr_ld(ld),
    .outr_outdata(outr0), .fgo_outdata(fgo0), .tx_serial(tx0),
    .tx_busy(busy0), .ovr_err(ovr0)
  );

  outr_serial_tx #(.CLKS_PER_BIT(2)) dut1 (
    .clk(clk), .reset(reset), .outr_indata(din), .outr_ld(ld),
    .outr_outdata(outr1), .fgo_outdata(fgo1), .tx_serial(tx1),
    .tx_busy(busy1), .ovr_err(ovr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is the edge index at which the load was accepted; outputs
  // after edge n follow from d = n - start via frame[d / cpb].
  int         cyc = 0;
  int         m_start[2] = '{0, 0};
  bit         m_have[2]  = '{1'b0, 1'b0};
  logic [7:0] m_outr[2]  = '{8'h00, 8'h00};
  bit         m_ovr[2]   = '{1'b0, 1'b0};

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic exp_busy(input int i);
    return m_have[i] && ((cyc - m_start[i]) < 10 * cpb(i));
  endfunction

  function automatic logic exp_tx(input int i);
    int s;
    if (!exp_busy(i)) return 1'b1;
    s = (cyc - m_start[i]) / cpb(i);
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return m_outr[i][s-1];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_have[i] = 1'b0;
        m_outr[i] = 8'h00;
        m_ovr[i]  = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (ld) begin
          if (!m_have[i] || (cyc - m_start[i] >= 10 * cpb(i) + 1)) begin
            m_have[i]  = 1'b1;
            m_start[i] = cyc;
            m_outr[i]  = din;
            m_ovr[i]   = 1'b0;
          end else begin
            m_ovr[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("tx0",   32'(tx0),   32'(exp_tx(0)));
    chk("fgo0",  32'(fgo0),  32'(!exp_busy(0)));
    chk("busy0", 32'(busy0), 32'(exp_busy(0)));
    chk("outr0", 32'(outr0), 32'(m_outr[0]));
    chk("ovr0",  32'(ovr0),  32'(m_ovr[0]));
    chk("tx1",   32'(tx1),   32'(exp_tx(1)));
    chk("fgo1",  32'(fgo1),  32'(!exp_busy(1)));
    chk("busy1", 32'(busy1), 32'(exp_busy(1)));
    chk("outr1", 32'(outr1), 32'(m_outr[1]));
    chk("ovr1",  32'(ovr1),  32'(m_ovr[1]));
  end

  // Loads 'data', samples instance d for 60 cycles from the accepting edge,
  // checks the per-slot line levels and the FGO-low duration; optional
  // overrun pulse of 8'hFF sampled at frame cycle pulse_at.
  task automatic frame_check(input int d, input logic [7:0] data, input logic [9:0] slots,
                             input int pulse_at, input string tag);
    logic       txs[60];
    logic       fg[60];
    logic [9:0] got;
    int         c;
    int         lows;
    c = cpb(d);
    @(negedge clk); #1;
    din = data;
    ld  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      txs[i] = (d == 0) ? tx0 : tx1;
      fg[i]  = (d == 0) ? fgo0 : fgo1;
      #1;
      if (i == 0) ld = 1'b0;
      if (pulse_at > 0 && i == pulse_at - 1) begin
        ld  = 1'b1;
        din = 8'hFF;
      end
      if (pulse_at > 0 && i == pulse_at) ld = 1'b0;
    end
    got  = '0;
    lows = 0;
    for (int s = 0; s < 10; s++) got[s] = txs[s * c + c / 2];
    for (int i = 0; i < 60; i++) if (fg[i] == 1'b0) lows++;
    chk({tag, "_slots"}, 32'(got), 32'(slots));
    chk({tag, "_fgo_low_cycles"}, 32'(lows), 32'(10 * c));
    chk({tag, "_fgo_back"}, 32'(fg[10 * c]), 32'd1);
  endtask

  initial begin
    logic s55[130];
    int   mism;
    int   lows;

    reset = 1'b0;
    ld    = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    repeat (100) @(negedge clk);
    chk("idle_tx",   32'(tx0),   32'd1);
    chk("idle_fgo",  32'(fgo0),  32'd1);
    chk("idle_outr", 32'(outr0), 32'h00);
    chk("idle_ovr",  32'(ovr0),  32'd0);

    frame_check(0, 8'hA5, 10'b1101001010, 0, "a5");
    chk("a5_outr", 32'(outr0), 32'hA5);

    frame_check(0, 8'h3C, 10'b1001111000, 15, "ovr3c");
    chk("ovr3c_outr", 32'(outr0), 32'h3C);
    chk("ovr3c_ovr",  32'(ovr0),  32'd1);
    frame_check(0, 8'h00, 10'b1000000000, 0, "clr00");
    chk("clr00_ovr", 32'(ovr0), 32'd0);

    @(negedge clk); #1;
    din = 8'hFF;
    ld  = 1'b1;
    @(negedge clk); #1;
    ld = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_tx",   32'(tx0),   32'd1);
    chk("rst_fgo",  32'(fgo0),  32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_outr", 32'(outr0), 32'h00);
    @(negedge clk); #1 reset = 1'b1;
    frame_check(0, 8'h01, 10'b1000000010, 0, "post_rst");

    repeat (10) @(negedge clk);
    #1 din = 8'h55;
    ld = 1'b1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      s55[i] = fgo0;
    end
    #1 ld = 1'b0;
    mism = 0;
    lows = 0;
    for (int i = 0; i < 123; i++) begin
      if (s55[i] !== ((i % 41) == 40)) mism++;
      if (s55[i] === 1'b0) lows++;
    end
    chk("cont_pattern_mismatches", 32'(mism), 32'd0);
    chk("cont_fgo_low_cycles", 32'(lows), 32'd120);

    repeat (50) @(negedge clk);
    frame_check(1, 8'h80, 10'b1100000000, 0, "c2_80");
    chk("c2_80_outr", 32'(outr1), 32'h80);

    repeat (600) begin
      @(negedge clk); #1;
      ld    = ($urandom_range(0, 7) == 0);
      din   = 8'($urandom);
      reset = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk); #1;
    ld    = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
